// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcodes, ALU op codes and the per-stage control bundle.
// Purely declarative; no timing or flow control of its own.
package ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_MUL   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       reg_write;
        logic [4:0] rd;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Only a MUL carries the MUL ALU op, so the op code alone identifies it.
    function automatic logic is_mul(input ctrl_t c);
        return c.alu_op == ALU_MUL;
    endfunction

endpackage

// File: rtl/control_decode.sv
// ID-stage decoder: opcode/funct7/valid to control bundle plus register-use flags.
// Combinational, zero latency; no flow control.
module control_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic       rs1_used,
    output logic       rs2_used
);

    logic known;

    always_comb begin
        ctrl     = BUBBLE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        known    = 1'b0;
        if (valid) begin
            known = 1'b1;
            case (opcode)
                OPC_RTYPE: begin
                    ctrl.alu_op    = (ENABLE_MUL && funct7 == FUNCT7_MUL) ? ALU_MUL : ALU_RTYPE;
                    ctrl.reg_write = 1'b1;
                    rs1_used       = 1'b1;
                    rs2_used       = 1'b1;
                end
                OPC_ITYPE: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    rs1_used       = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_read  = 1'b1;
                    ctrl.mem_2_reg = 1'b1;
                    ctrl.reg_write = 1'b1;
                    rs1_used       = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    rs1_used       = 1'b1;
                    rs2_used       = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                    rs1_used    = 1'b1;
                    rs2_used    = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.jump = 1'b1;
                end
                default: known = 1'b0;
            endcase
            if (known) begin
                ctrl.rd = rd;
            end
        end
    end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit: decodes ID and carries control through ID/EX, EX/MEM, MEM/WB.
// One cycle per stage; load-use, multi-cycle MUL stalls and branch/jump flushes via pc_write/if_id_write/if_flush.
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int ENABLE_MUL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [6:0] id_funct7,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       ex_branch_taken,
    output logic [1:0] ex_alu_op,
    output logic       ex_alu_src,
    output logic       ex_branch,
    output logic       ex_jump,
    output logic [4:0] ex_rd,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       wb_reg_write,
    output logic       wb_mem_2_reg,
    output logic [4:0] wb_rd,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_flush,
    output logic       mul_busy
);

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

    ctrl_t      dec;
    ctrl_t      id_ex;
    ctrl_t      ex_mem;
    ctrl_t      mem_wb;
    logic       rs1_used;
    logic       rs2_used;
    logic [3:0] mul_cnt;
    logic       br_flush;
    logic       mul_stall;
    logic       load_use;
    logic       hold;

    control_decode #(
        .ENABLE_MUL (ENABLE_MUL != 0)
    ) u_decode (
        .valid    (id_valid),
        .opcode   (id_opcode),
        .funct7   (id_funct7),
        .rd       (id_rd),
        .ctrl     (dec),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign br_flush  = id_ex.branch & ex_branch_taken;
    assign mul_stall = (mul_cnt != 4'd0);
    assign load_use  = id_ex.mem_read && (id_ex.rd != 5'd0) &&
                       ((rs1_used && (id_ex.rd == id_rs1)) ||
                        (rs2_used && (id_ex.rd == id_rs2)));

    // A taken branch discards whatever is in ID, so it overrides any stall request.
    assign hold = !br_flush && (mul_stall || load_use);

    assign pc_write    = rst || !hold;
    assign if_id_write = rst || !hold;
    assign if_flush    = !rst && (br_flush || (!mul_stall && !load_use && dec.jump));
    assign mul_busy    = !rst && mul_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex   <= BUBBLE;
            ex_mem  <= BUBBLE;
            mem_wb  <= BUBBLE;
            mul_cnt <= 4'd0;
        end else begin
            mem_wb <= ex_mem;
            if (br_flush) begin
                id_ex  <= BUBBLE;
                ex_mem <= id_ex;
            end else if (mul_stall) begin
                ex_mem  <= BUBBLE;
                mul_cnt <= mul_cnt - 4'd1;
            end else if (load_use) begin
                id_ex  <= BUBBLE;
                ex_mem <= id_ex;
            end else begin
                id_ex  <= dec;
                ex_mem <= id_ex;
                if (is_mul(dec)) begin
                    mul_cnt <= MUL_CNT_INIT;
                end
            end
        end
    end

    assign ex_alu_op     = id_ex.alu_op;
    assign ex_alu_src    = id_ex.alu_src;
    assign ex_branch     = id_ex.branch;
    assign ex_jump       = id_ex.jump;
    assign ex_rd         = id_ex.rd;
    assign mem_mem_read  = ex_mem.mem_read;
    assign mem_mem_write = ex_mem.mem_write;
    assign wb_reg_write  = mem_wb.reg_write;
    assign wb_mem_2_reg  = mem_wb.mem_2_reg;
    assign wb_rd         = mem_wb.rd;

    // Late-stage fields that only ride along to keep the bundle uniform.
    logic unused_fields;
    assign unused_fields = ^{ex_mem.alu_op, ex_mem.alu_src, ex_mem.branch, ex_mem.jump,
                             mem_wb.alu_op, mem_wb.alu_src, mem_wb.branch, mem_wb.jump,
                             mem_wb.mem_read, mem_wb.mem_write};

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: three instances (MUL_LATENCY 3, MUL_LATENCY 1, MUL disabled) share stimulus.
// Expected values are queued with their due cycle; a negedge monitor pops and compares them.
module tb_control_pipe;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int S_PCW   = 0;
    localparam int S_IFIDW = 1;
    localparam int S_FLUSH = 2;
    localparam int S_BUSY  = 3;
    localparam int S_ALUOP = 4;
    localparam int S_EXBR  = 5;
    localparam int S_EXJ   = 6;
    localparam int S_EXRD  = 7;
    localparam int S_EXANY = 8;
    localparam int S_MRD   = 9;
    localparam int S_MWR   = 10;
    localparam int S_WBRW  = 11;
    localparam int S_WBM2R = 12;
    localparam int S_WBRD  = 13;
    localparam int L1      = 20;
    localparam int NM      = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [6:0] id_funct7;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       ex_branch_taken;

    logic [1:0] ex_alu_op     [3];
    logic       ex_alu_src    [3];
    logic       ex_branch     [3];
    logic       ex_jump       [3];
    logic [4:0] ex_rd         [3];
    logic       mem_mem_read  [3];
    logic       mem_mem_write [3];
    logic       wb_reg_write  [3];
    logic       wb_mem_2_reg  [3];
    logic [4:0] wb_rd         [3];
    logic       pc_write      [3];
    logic       if_id_write   [3];
    logic       if_flush      [3];
    logic       mul_busy      [3];

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_pipe #(.MUL_LATENCY(3), .ENABLE_MUL(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .ex_alu_op(ex_alu_op[0]), .ex_alu_src(ex_alu_src[0]), .ex_branch(ex_branch[0]),
        .ex_jump(ex_jump[0]), .ex_rd(ex_rd[0]), .mem_mem_read(mem_mem_read[0]),
        .mem_mem_write(mem_mem_write[0]), .wb_reg_write(wb_reg_write[0]),
        .wb_mem_2_reg(wb_mem_2_reg[0]), .wb_rd(wb_rd[0]), .pc_write(pc_write[0]),
        .if_id_write(if_id_write[0]), .if_flush(if_flush[0]), .mul_busy(mul_busy[0])
    );

    control_pipe #(.MUL_LATENCY(1), .ENABLE_MUL(1)) dut_l1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .ex_alu_op(ex_alu_op[1]), .ex_alu_src(ex_alu_src[1]), .ex_branch(ex_branch[1]),
        .ex_jump(ex_jump[1]), .ex_rd(ex_rd[1]), .mem_mem_read(mem_mem_read[1]),
        .mem_mem_write(mem_mem_write[1]), .wb_reg_write(wb_reg_write[1]),
        .wb_mem_2_reg(wb_mem_2_reg[1]), .wb_rd(wb_rd[1]), .pc_write(pc_write[1]),
        .if_id_write(if_id_write[1]), .if_flush(if_flush[1]), .mul_busy(mul_busy[1])
    );

    control_pipe #(.MUL_LATENCY(3), .ENABLE_MUL(0)) dut_nm (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .ex_alu_op(ex_alu_op[2]), .ex_alu_src(ex_alu_src[2]), .ex_branch(ex_branch[2]),
        .ex_jump(ex_jump[2]), .ex_rd(ex_rd[2]), .mem_mem_read(mem_mem_read[2]),
        .mem_mem_write(mem_mem_write[2]), .wb_reg_write(wb_reg_write[2]),
        .wb_mem_2_reg(wb_mem_2_reg[2]), .wb_rd(wb_rd[2]), .pc_write(pc_write[2]),
        .if_id_write(if_id_write[2]), .if_flush(if_flush[2]), .mul_busy(mul_busy[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] get_sig(input int s);
        int k;
        k = s / 20;
        case (s % 20)
            S_PCW:   return 8'(pc_write[k]);
            S_IFIDW: return 8'(if_id_write[k]);
            S_FLUSH: return 8'(if_flush[k]);
            S_BUSY:  return 8'(mul_busy[k]);
            S_ALUOP: return 8'(ex_alu_op[k]);
            S_EXBR:  return 8'(ex_branch[k]);
            S_EXJ:   return 8'(ex_jump[k]);
            S_EXRD:  return 8'(ex_rd[k]);
            S_EXANY: return 8'(|{ex_alu_op[k], ex_alu_src[k], ex_branch[k], ex_jump[k], ex_rd[k]});
            S_MRD:   return 8'(mem_mem_read[k]);
            S_MWR:   return 8'(mem_mem_write[k]);
            S_WBRW:  return 8'(wb_reg_write[k]);
            S_WBM2R: return 8'(wb_mem_2_reg[k]);
            S_WBRD:  return 8'(wb_rd[k]);
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: every expectation due this cycle is compared; overdue ones count as failures.
    always @(negedge clk) begin
        int         nc;
        int         ne;
        logic [7:0] act;
        nc = 0;
        ne = 0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                nc++;
                act = get_sig(sb[i].sig);
                if (sb[i].cyc < cyc) begin
                    ne++;
                    $display("FAIL %s: not compared at cycle %0d (now %0d)", sb[i].nm, sb[i].cyc, cyc);
                end else if (act !== sb[i].val) begin
                    ne++;
                    $display("FAIL %s: cycle %0d got %0h expected %0h", sb[i].nm, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
        checks <= checks + nc;
        errors <= errors + ne;
    end

    task automatic expect_at(input int dc, input int s, input int v, input string nm);
        exp_t e;
        e.cyc = cyc + dc;
        e.sig = s;
        e.val = 8'(v);
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        id_valid  = v;
        id_opcode = op;
        id_funct7 = f7;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = d;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst             = 1'b1;
        ex_branch_taken = 1'b0;
        drive(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd3);

        // Reset held two cycles with an ADD present
        tick();
        expect_at(0, S_EXANY, 0, "rst_ex_zero");
        expect_at(0, S_MRD, 0, "rst_mem_read");
        expect_at(0, S_WBRW, 0, "rst_wb_reg_write");
        expect_at(0, S_PCW, 1, "rst_pc_write");
        expect_at(0, S_IFIDW, 1, "rst_if_id_write");
        expect_at(0, S_FLUSH, 0, "rst_if_flush");
        expect_at(0, S_BUSY, 0, "rst_mul_busy");
        tick();
        rst = 1'b0;
        expect_at(1, S_ALUOP, 2, "rst_add_ex");
        expect_at(2, S_WBRW, 0, "rst_add_not_early");
        expect_at(3, S_WBRW, 1, "rst_add_wb");
        expect_at(3, S_WBRD, 3, "rst_add_wb_rd");
        tick(); idle();
        repeat (4) tick();

        // Load-use: lw x5 then add x6,x5,x1
        drive(1'b1, OP_LD, 7'd0, 5'd2, 5'd0, 5'd5);
        expect_at(1, S_PCW, 0, "lu_pc_write");
        expect_at(1, S_IFIDW, 0, "lu_if_id_write");
        expect_at(2, S_EXANY, 0, "lu_ex_bubble");
        expect_at(2, S_PCW, 1, "lu_one_cycle");
        expect_at(2, S_MRD, 1, "lu_load_in_mem");
        expect_at(3, S_ALUOP, 2, "lu_add_ex");
        expect_at(3, S_WBM2R, 1, "lu_load_wb_m2r");
        tick(); drive(1'b1, OP_R, 7'd0, 5'd5, 5'd1, 5'd6);
        tick();
        tick(); idle();
        repeat (3) tick();

        // Load to x0 never stalls
        drive(1'b1, OP_LD, 7'd0, 5'd2, 5'd0, 5'd0);
        expect_at(1, S_PCW, 1, "lu_x0_no_stall");
        expect_at(2, S_ALUOP, 2, "lu_x0_add_ex");
        tick(); drive(1'b1, OP_R, 7'd0, 5'd0, 5'd1, 5'd6);
        tick(); idle();
        repeat (2) tick();

        // I-type does not use its rs2 field
        drive(1'b1, OP_LD, 7'd0, 5'd2, 5'd0, 5'd7);
        expect_at(1, S_PCW, 1, "lu_itype_rs2_unused");
        tick(); drive(1'b1, OP_I, 7'd0, 5'd1, 5'd7, 5'd8);
        tick(); idle();
        repeat (2) tick();

        // Store uses rs2
        drive(1'b1, OP_LD, 7'd0, 5'd2, 5'd0, 5'd4);
        expect_at(1, S_PCW, 0, "lu_store_rs2");
        expect_at(4, S_MWR, 1, "store_mem_write");
        tick(); drive(1'b1, OP_ST, 7'd0, 5'd3, 5'd4, 5'd0);
        tick();
        tick(); idle();
        repeat (3) tick();

        // JAL ignores rs1: no stall, immediate flush
        drive(1'b1, OP_LD, 7'd0, 5'd2, 5'd0, 5'd1);
        expect_at(1, S_PCW, 1, "jal_no_load_use");
        expect_at(1, S_FLUSH, 1, "jal_flush");
        tick(); drive(1'b1, OP_JAL, 7'd0, 5'd1, 5'd0, 5'd2);
        tick(); idle();
        repeat (2) tick();

        // MUL then ADD
        drive(1'b1, OP_R, 7'b0000001, 5'd1, 5'd2, 5'd8);
        expect_at(1, S_BUSY, 1, "mul_busy_1");
        expect_at(2, S_BUSY, 1, "mul_busy_2");
        expect_at(3, S_BUSY, 0, "mul_busy_end");
        expect_at(1, S_PCW, 0, "mul_pc_write_1");
        expect_at(2, S_PCW, 0, "mul_pc_write_2");
        expect_at(3, S_PCW, 1, "mul_pc_write_end");
        expect_at(2, S_IFIDW, 0, "mul_if_id_write");
        expect_at(1, S_ALUOP, 3, "mul_alu_op");
        expect_at(3, S_ALUOP, 3, "mul_held_in_ex");
        expect_at(4, S_ALUOP, 2, "mul_next_add");
        expect_at(4, S_WBRW, 0, "mul_wb_bubble");
        expect_at(5, S_WBRW, 1, "mul_wb");
        expect_at(5, S_WBRD, 8, "mul_wb_rd");
        expect_at(1, L1 + S_BUSY, 0, "l1_no_busy");
        expect_at(1, L1 + S_PCW, 1, "l1_no_stall");
        expect_at(1, L1 + S_ALUOP, 3, "l1_mul_alu_op");
        expect_at(2, L1 + S_ALUOP, 2, "l1_next_add");
        expect_at(1, NM + S_ALUOP, 2, "nomul_funct7_1");
        expect_at(1, NM + S_BUSY, 0, "nomul_no_busy");
        expect_at(2, NM + S_ALUOP, 2, "nomul_funct7_0");
        tick(); drive(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd9);
        tick();
        tick();
        tick(); idle();
        repeat (3) tick();

        // Taken branch in EX; then taken asserted with no branch in EX
        drive(1'b1, OP_BR, 7'd0, 5'd1, 5'd2, 5'd0);
        expect_at(1, S_EXBR, 1, "br_in_ex");
        expect_at(1, S_FLUSH, 1, "br_flush");
        expect_at(1, S_PCW, 1, "br_pc_write");
        expect_at(2, S_EXANY, 0, "br_ex_bubble");
        expect_at(2, S_FLUSH, 0, "br_taken_no_branch");
        expect_at(3, S_EXRD, 11, "br_next_instr");
        tick(); drive(1'b1, OP_I, 7'd0, 5'd1, 5'd0, 5'd10); ex_branch_taken = 1'b1;
        tick(); drive(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd11);
        tick(); idle(); ex_branch_taken = 1'b0;
        repeat (2) tick();

        // JAL waiting behind a MUL stall
        drive(1'b1, OP_R, 7'b0000001, 5'd1, 5'd2, 5'd12);
        expect_at(1, S_FLUSH, 0, "jal_stalled_1");
        expect_at(2, S_FLUSH, 0, "jal_stalled_2");
        expect_at(3, S_FLUSH, 1, "jal_after_stall");
        expect_at(4, S_EXJ, 1, "jal_in_ex");
        tick(); drive(1'b1, OP_JAL, 7'd0, 5'd0, 5'd0, 5'd1);
        tick();
        tick();
        tick(); idle();
        repeat (3) tick();

        // Reset mid-MUL discards it
        drive(1'b1, OP_R, 7'b0000001, 5'd1, 5'd2, 5'd13);
        expect_at(1, S_BUSY, 0, "rmul_busy_in_rst");
        expect_at(1, S_PCW, 1, "rmul_pc_write_in_rst");
        expect_at(2, S_BUSY, 0, "rmul_busy_cleared");
        expect_at(2, S_EXANY, 0, "rmul_ex_cleared");
        expect_at(2, S_PCW, 1, "rmul_pc_write");
        expect_at(5, S_WBRW, 0, "rmul_discarded");
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
